multicycle_control: RTL

//  Multi-cycle MIPS main control: Moore FSM that sequences fetch/decode/execute/memory/writeback
//  and drives all datapath enables per state. Next generation of the single-cycle opcode decoder:

---
 rtl/multicycle_pkg.sv | 69 ++++++
 rtl/multicycle_control_if.sv | 39 +++
 rtl/multicycle_ctrl_decode.sv | 76 +++++++
 rtl/multicycle_control.sv | 106 ++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// multicycle_pkg
//   Shared definitions for the multi-cycle MIPS main control: state codes,
//   opcode constants, datapath select encodings and the control-word struct
//   produced by the decoder.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_ADDI_EX = 4'd11,
    S_ORI_EX  = 4'd12,
    S_IWB     = 4'd13,
    S_ILLEGAL = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_OR    = 2'b10;
  localparam logic [1:0] ALU_FUNCT = 2'b11;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  // States that hold for the memory wait counter before completing.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Bundle between the main control and the multi-cycle datapath.
//   Op_i            opcode from IR (datapath -> control)
//   PCWrite_o..     datapath enables/selects (control -> datapath)
//   Illegal_o       unsupported-opcode pulse
//   State_o         current state code, debug visibility
//   master: the control FSM; slave: the datapath side.
interface multicycle_control_if;
  logic [5:0] Op_i;
  logic       PCWrite_o;
  logic       PCWriteCond_o;
  logic       IorD_o;
  logic       MemRead_o;
  logic       MemWrite_o;
  logic       IRWrite_o;
  logic       MemtoReg_o;
  logic       RegDst_o;
  logic       RegWrite_o;
  logic       ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic [1:0] ALUOp_o;
  logic [1:0] PCSource_o;
  logic       Illegal_o;
  logic [3:0] State_o;

  modport master (
    input  Op_i,
    output PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
           MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
           PCSource_o, Illegal_o, State_o
  );

  modport slave (
    output Op_i,
    input  PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
           MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
           PCSource_o, Illegal_o, State_o
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode
//   Combinational Moore output decode: state (+ final-wait flag) -> control word.
//   state      current FSM state
//   last_wait  wait counter has reached MEM_WAIT (only FETCH cares)
//   ctrl       datapath control word; anything not named for a state is 0
module multicycle_ctrl_decode
  import multicycle_pkg::*;
(
  input  state_t state,
  input  logic   last_wait,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        // IR and PC update only once the memory has delivered the word
        ctrl.ir_write  = last_wait;
        ctrl.pc_write  = last_wait;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_ORI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_OR;
      end
      S_IWB:     ctrl.reg_write = 1'b1;
      S_ILLEGAL: ctrl.illegal   = 1'b1;
      default:   ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle MIPS main control. Moore FSM sequencing fetch/decode/execute/
//   memory/writeback with a parametrised memory wait and illegal-opcode trap.
//   MEM_WAIT  extra cycles each memory state holds (0..15)
//   ORI_EN    1: opcode 0x0D executes as ori, 0: trapped as illegal
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-high reset
//   bus       control bundle (master side): Op_i in, datapath enables out
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter bit ORI_EN   = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  multicycle_control_if.master bus
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       last_wait;
  logic       is_store;
  ctrl_t      ctrl;

  assign last_wait = (cnt == WAIT_LAST);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_RST;
    else       state <= state_nxt;
  end

  // Wait counter: counts inside a memory state and falls back to 0 on the
  // completing cycle, so it is already clear on entry to the next one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                  cnt <= 4'd0;
    else if (is_mem_state(state) && !last_wait) cnt <= cnt + 4'd1;
    else                                        cnt <= 4'd0;
  end

  // Op_i is only valid in DECODE; remember lw vs sw for the MEMADR branch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   is_store <= 1'b0;
    else if (state == S_DECODE) is_store <= (bus.Op_i == OP_SW);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:    state_nxt = S_FETCH;
      S_FETCH:  if (last_wait) state_nxt = S_DECODE;
      S_DECODE: begin
        case (bus.Op_i)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = S_ADDI_EX;
          OP_ORI:       state_nxt = ORI_EN ? S_ORI_EX : S_ILLEGAL;
          default:      state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  state_nxt = is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (last_wait) state_nxt = S_MEMWB;
      S_MEMWR:   if (last_wait) state_nxt = S_FETCH;
      S_EXEC:    state_nxt = S_RWB;
      S_ADDI_EX,
      S_ORI_EX:  state_nxt = S_IWB;
      S_MEMWB,
      S_RWB,
      S_BRANCH,
      S_JUMP,
      S_IWB,
      S_ILLEGAL: state_nxt = S_FETCH;
      default:   state_nxt = S_RST;
    endcase
  end

  // Output decode
  multicycle_ctrl_decode u_decode (
    .state     (state),
    .last_wait (last_wait),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite_o     = ctrl.pc_write;
  assign bus.PCWriteCond_o = ctrl.pc_write_cond;
  assign bus.IorD_o        = ctrl.iord;
  assign bus.MemRead_o     = ctrl.mem_read;
  assign bus.MemWrite_o    = ctrl.mem_write;
  assign bus.IRWrite_o     = ctrl.ir_write;
  assign bus.MemtoReg_o    = ctrl.mem_to_reg;
  assign bus.RegDst_o      = ctrl.reg_dst;
  assign bus.RegWrite_o    = ctrl.reg_write;
  assign bus.ALUSrcA_o     = ctrl.alu_src_a;
  assign bus.ALUSrcB_o     = ctrl.alu_src_b;
  assign bus.ALUOp_o       = ctrl.alu_op;
  assign bus.PCSource_o    = ctrl.pc_source;
  assign bus.Illegal_o     = ctrl.illegal;
  assign bus.State_o       = state;

endmodule
